// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared sequencer states, trap causes, access kinds and default vectors
package core_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    DECODE     = 3'd1,
    EXEC       = 3'd2,
    MEM        = 3'd3,
    WRITE_BACK = 3'd4,
    TRAP       = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL       = 2'd0,
    CAUSE_FETCH_TIMEOUT = 2'd1,
    CAUSE_DATA_TIMEOUT  = 2'd2,
    CAUSE_MISALIGNED    = 2'd3
  } trap_cause_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h8000_0100;

endpackage

// File: rtl/seq_timeout_counter.sv
// rtl/seq_timeout_counter.sv - wait-cycle counter flagging the last allowed memory wait cycle
module seq_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry marks the TIMEOUT-th waiting cycle; the owner lets a same-cycle rvalid win.
  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - RV32 multi-cycle control sequencer; SEQ_INSTRET_EN adds the instret counter
module core_sequencer
  import core_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEFAULT_TRAP_VEC),
  parameter int              TIMEOUT   = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     inst_o,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic            illegal_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] target_i,
  input  logic [4:0]      rd_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  input  logic            dmem_rvalid_i,
  output logic            rf_we_o,
  output logic [XLEN-1:0] pc_o,
  output logic            retire_o,
  output logic            trap_o,
  output logic [1:0]      trap_cause_o,
  output logic [XLEN-1:0] epc_o,
  output logic [63:0]     instret_o
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [31:0]     inst_q, inst_d;
  trap_cause_e     cause_q, cause_d;
  logic [XLEN-1:0] target_sel;
  logic            waiting;
  logic            expired;

  assign waiting = (state_q == FETCH) || (state_q == MEM);

  seq_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (!waiting),
    .enable_i  (waiting),
    .expired_o (expired)
  );

  always_comb begin
    if (is_jal_i || is_jalr_i || (is_branch_i && branch_taken_i)) begin
      target_sel = target_i;
    end else begin
      target_sel = pc_q + XLEN'(4);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    epc_d      = epc_q;
    inst_d     = inst_q;
    cause_d    = cause_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = READ;
    rf_we_o    = 1'b0;
    retire_o   = 1'b0;
    trap_o     = 1'b0;
    unique case (state_q)
      FETCH: begin
        // Gated by reset so no request leaks out while the core is held.
        imem_req_o = rst_ni;
        if (imem_rvalid_i) begin
          inst_d  = imem_rdata_i;
          state_d = DECODE;
        end else if (expired) begin
          cause_d = CAUSE_FETCH_TIMEOUT;
          state_d = TRAP;
        end
      end
      DECODE: begin
        if (illegal_i) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = TRAP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        npc_d = target_sel;
        if (target_sel[1:0] != 2'b00) begin
          cause_d = CAUSE_MISALIGNED;
          state_d = TRAP;
        end else if (is_load_i || is_store_i) begin
          state_d = MEM;
        end else begin
          state_d = WRITE_BACK;
        end
      end
      MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store_i ? WRITE : READ;
        if (dmem_rvalid_i) begin
          state_d = WRITE_BACK;
        end else if (expired) begin
          cause_d = CAUSE_DATA_TIMEOUT;
          state_d = TRAP;
        end
      end
      WRITE_BACK: begin
        rf_we_o  = (rd_i != 5'd0) && !(is_store_i || is_branch_i);
        retire_o = 1'b1;
        pc_d     = npc_q;
        state_d  = FETCH;
      end
      TRAP: begin
        trap_o  = 1'b1;
        epc_d   = pc_q;
        pc_d    = TRAP_VEC;
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      pc_q    <= RESET_VEC;
      npc_q   <= RESET_VEC;
      epc_q   <= '0;
      inst_q  <= '0;
      cause_q <= CAUSE_ILLEGAL;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      epc_q   <= epc_d;
      inst_q  <= inst_d;
      cause_q <= cause_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign epc_o        = epc_q;
  assign trap_cause_o = cause_q;

`ifdef SEQ_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  assign instret_d = retire_o ? (instret_q + 64'd1) : instret_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;
  import core_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] RV = 32'h8000_0000;
  localparam logic [31:0] TV = 32'h8000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;
  logic [31:0]     inst_o;
  logic            is_load_i, is_store_i, is_branch_i, is_jal_i, is_jalr_i, illegal_i;
  logic            branch_taken_i;
  logic [XLEN-1:0] target_i;
  logic [4:0]      rd_i;
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic            dmem_rvalid_i;
  logic            rf_we_o;
  logic [XLEN-1:0] pc_o;
  logic            retire_o;
  logic            trap_o;
  logic [1:0]      trap_cause_o;
  logic [XLEN-1:0] epc_o;
  logic [63:0]     instret_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  core_sequencer #(
    .XLEN(XLEN), .RESET_VEC(RV), .TRAP_VEC(TV), .TIMEOUT(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .inst_o(inst_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .is_branch_i(is_branch_i),
    .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .illegal_i(illegal_i),
    .branch_taken_i(branch_taken_i), .target_i(target_i), .rd_i(rd_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_rvalid_i(dmem_rvalid_i),
    .rf_we_o(rf_we_o), .pc_o(pc_o), .retire_o(retire_o), .trap_o(trap_o),
    .trap_cause_o(trap_cause_o), .epc_o(epc_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic set_flags(input logic ld, input logic st, input logic br, input logic jl,
                           input logic ill, input logic tk, input logic [31:0] tgt,
                           input logic [4:0] rd);
    is_load_i = ld; is_store_i = st; is_branch_i = br; is_jal_i = jl; is_jalr_i = 1'b0;
    illegal_i = ill; branch_taken_i = tk; target_i = tgt; rd_i = rd;
  endtask

  // From the first FETCH cycle: lat idle cycles, then one rvalid cycle; ends in DECODE.
  task automatic fetch(input logic [31:0] data, input int lat);
    repeat (lat) step();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; dmem_rvalid_i = 1'b0;
    set_flags(0, 0, 0, 0, 0, 0, '0, '0);
    repeat (3) step();
    checks++;
    if (pc_o !== RV) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_o, RV); end
    checks++;
    if ({imem_req_o, dmem_req_o, rf_we_o, retire_o, trap_o} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000",
                         {imem_req_o, dmem_req_o, rf_we_o, retire_o, trap_o});
    end
    checks++;
    if ({inst_o, epc_o, trap_cause_o} !== 66'b0) begin
      errors++; $display("FAIL reset_regs: inst %h epc %h cause %0d expected all 0", inst_o, epc_o, trap_cause_o);
    end
    checks++;
    if (instret_o !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret_o); end
    rst_ni = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RV) begin
      errors++; $display("FAIL reset_release_fetch: req %b addr %h expected 1 %h", imem_req_o, imem_addr_o, RV);
    end
  endtask

  task automatic test_nop();
    logic [31:0] exp_pc;
    int last_ret;
    exp_pc = RV;
    last_ret = 0;
    set_flags(0, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_addr_o !== exp_pc) begin errors++; $display("FAIL nop_addr: got %h expected %h", imem_addr_o, exp_pc); end
      fetch(NOP, 1);
      checks++;
      if (inst_o !== NOP || imem_req_o !== 1'b0) begin
        errors++; $display("FAIL nop_decode: inst %h req %b expected %h 0", inst_o, imem_req_o, NOP);
      end
      step();
      step();
      checks++;
      if (retire_o !== 1'b1 || rf_we_o !== 1'b0) begin
        errors++; $display("FAIL nop_retire: retire %b rf_we %b expected 1 0", retire_o, rf_we_o);
      end
      if (i > 0) begin
        checks++;
        if (cyc - last_ret !== 5) begin errors++; $display("FAIL nop_period: got %0d expected 5", cyc - last_ret); end
      end
      last_ret = cyc;
      step();
      exp_pc = exp_pc + 32'd4;
    end
    checks++;
    if (pc_o !== 32'h8000_000C) begin errors++; $display("FAIL nop_pc_end: got %h expected 8000000c", pc_o); end
  endtask

  task automatic test_load_store();
    int req_cnt;
    req_cnt = 0;
    set_flags(1, 0, 0, 0, 0, 0, '0, 5'd5);
    fetch(32'h0002_a283, 1);
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      if (dmem_req_o === 1'b1 && dmem_we_o === 1'b0) req_cnt++;
      if (k == 2) dmem_rvalid_i = 1'b1;
      step();
    end
    dmem_rvalid_i = 1'b0;
    checks++;
    if (req_cnt !== 3 || dmem_req_o !== 1'b0) begin
      errors++; $display("FAIL load_req: read cycles %0d req now %b expected 3 0", req_cnt, dmem_req_o);
    end
    checks++;
    if (rf_we_o !== 1'b1 || retire_o !== 1'b1) begin
      errors++; $display("FAIL load_wb: rf_we %b retire %b expected 1 1", rf_we_o, retire_o);
    end
    step();
    checks++;
    if (rf_we_o !== 1'b0 || pc_o !== 32'h8000_0010) begin
      errors++; $display("FAIL load_after: rf_we %b pc %h expected 0 80000010", rf_we_o, pc_o);
    end
    set_flags(0, 1, 0, 0, 0, 0, '0, 5'd5);
    fetch(32'h0050_a023, 1);
    step();
    step();
    checks++;
    if (dmem_req_o !== 1'b1 || dmem_we_o !== WRITE) begin
      errors++; $display("FAIL store_req: req %b we %b expected 1 1", dmem_req_o, dmem_we_o);
    end
    dmem_rvalid_i = 1'b1;
    step();
    dmem_rvalid_i = 1'b0;
    checks++;
    if (rf_we_o !== 1'b0 || retire_o !== 1'b1) begin
      errors++; $display("FAIL store_wb: rf_we %b retire %b expected 0 1", rf_we_o, retire_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h8000_0014) begin errors++; $display("FAIL store_pc: got %h expected 80000014", pc_o); end
  endtask

  task automatic test_branch();
    set_flags(0, 0, 1, 0, 0, 1, 32'h8000_0040, 5'd0);
    fetch(32'h0000_0463, 1);
    step();
    step();
    step();
    checks++;
    if (imem_addr_o !== 32'h8000_0040) begin
      errors++; $display("FAIL branch_taken: got %h expected 80000040", imem_addr_o);
    end
    set_flags(0, 0, 1, 0, 0, 0, 32'h8000_0042, 5'd3);
    fetch(32'h0000_0463, 1);
    step();
    step();
    checks++;
    if (trap_o !== 1'b0 || rf_we_o !== 1'b0 || retire_o !== 1'b1) begin
      errors++; $display("FAIL branch_not_taken: trap %b rf_we %b retire %b expected 0 0 1", trap_o, rf_we_o, retire_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h8000_0044) begin errors++; $display("FAIL branch_nt_pc: got %h expected 80000044", pc_o); end
    set_flags(0, 0, 0, 1, 0, 0, 32'h8000_0080, 5'd1);
    fetch(32'h0000_00ef, 1);
    step();
    step();
    checks++;
    if (rf_we_o !== 1'b1) begin errors++; $display("FAIL jal_rf_we: got %b expected 1", rf_we_o); end
    step();
    checks++;
    if (pc_o !== 32'h8000_0080) begin errors++; $display("FAIL jal_pc: got %h expected 80000080", pc_o); end
    set_flags(0, 0, 1, 0, 0, 1, 32'h8000_0042, 5'd0);
    fetch(32'h0000_0463, 1);
    step();
    step();
    checks++;
    if (trap_o !== 1'b1 || trap_cause_o !== 2'd3 || retire_o !== 1'b0) begin
      errors++; $display("FAIL misaligned_trap: trap %b cause %0d retire %b expected 1 3 0", trap_o, trap_cause_o, retire_o);
    end
    step();
    checks++;
    if (pc_o !== TV || epc_o !== 32'h8000_0080 || trap_o !== 1'b0) begin
      errors++; $display("FAIL misaligned_after: pc %h epc %h trap %b expected 80000100 80000080 0", pc_o, epc_o, trap_o);
    end
  endtask

  task automatic test_illegal();
    set_flags(0, 0, 0, 0, 1, 0, '0, 5'd7);
    fetch(32'hffff_ffff, 1);
    step();
    checks++;
    if (trap_o !== 1'b1 || trap_cause_o !== 2'd0 || retire_o !== 1'b0 || rf_we_o !== 1'b0) begin
      errors++; $display("FAIL illegal_trap: trap %b cause %0d retire %b rf_we %b expected 1 0 0 0",
                         trap_o, trap_cause_o, retire_o, rf_we_o);
    end
    illegal_i = 1'b0;
    step();
    checks++;
    if (pc_o !== TV || epc_o !== TV) begin
      errors++; $display("FAIL illegal_after: pc %h epc %h expected 80000100 80000100", pc_o, epc_o);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    set_flags(0, 0, 0, 0, 0, 0, '0, '0);
    fetch(NOP, 1);
    step();
    step();
    step();
    repeat (15) begin
      step();
      if (trap_o !== 1'b0 || imem_req_o !== 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL fetch_wait: early exits %0d expected 0", early); end
    step();
    checks++;
    if (trap_o !== 1'b1 || trap_cause_o !== 2'd1) begin
      errors++; $display("FAIL fetch_timeout: trap %b cause %0d expected 1 1", trap_o, trap_cause_o);
    end
    step();
    checks++;
    if (imem_addr_o !== TV || epc_o !== 32'h8000_0104) begin
      errors++; $display("FAIL fetch_timeout_after: addr %h epc %h expected 80000100 80000104", imem_addr_o, epc_o);
    end
    repeat (15) step();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0010_0093;
    step();
    imem_rvalid_i = 1'b0;
    checks++;
    if (trap_o !== 1'b0 || imem_req_o !== 1'b0 || inst_o !== 32'h0010_0093) begin
      errors++; $display("FAIL rvalid_at_limit: trap %b req %b inst %h expected 0 0 00100093", trap_o, imem_req_o, inst_o);
    end
    step();
    step();
    checks++;
    if (retire_o !== 1'b1) begin errors++; $display("FAIL rvalid_at_limit_retire: got %b expected 1", retire_o); end
    step();
    set_flags(1, 0, 0, 0, 0, 0, '0, 5'd5);
    fetch(32'h0002_a283, 1);
    step();
    step();
    repeat (16) step();
    checks++;
    if (trap_o !== 1'b1 || trap_cause_o !== 2'd2 || rf_we_o !== 1'b0) begin
      errors++; $display("FAIL data_timeout: trap %b cause %0d rf_we %b expected 1 2 0", trap_o, trap_cause_o, rf_we_o);
    end
    step();
    checks++;
    if (pc_o !== TV || epc_o !== 32'h8000_0104) begin
      errors++; $display("FAIL data_timeout_after: pc %h epc %h expected 80000100 80000104", pc_o, epc_o);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    set_flags(1, 0, 0, 0, 0, 0, '0, 5'd5);
    fetch(32'h0002_a283, 1);
    step();
    step();
    step();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (pc_o !== RV || dmem_req_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid: pc %h dreq %b ireq %b expected 80000000 0 0", pc_o, dmem_req_o, imem_req_o);
    end
    checks++;
    if (trap_cause_o !== 2'd0 || epc_o !== 32'd0) begin
      errors++; $display("FAIL reset_mid_regs: cause %0d epc %h expected 0 0", trap_cause_o, epc_o);
    end
    dmem_rvalid_i = 1'b1;
    repeat (2) begin
      step();
      if (rf_we_o !== 1'b0 || retire_o !== 1'b0) bad++;
    end
    dmem_rvalid_i = 1'b0;
    rst_ni = 1'b1;
    repeat (3) begin
      step();
      if (rf_we_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== RV) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL reset_mid_after: bad cycles %0d expected 0", bad); end
    set_flags(0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic test_instret();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    set_flags(0, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      fetch(NOP, 1);
      step();
      step();
      step();
    end
    illegal_i = 1'b1;
    fetch(32'hffff_ffff, 1);
    step();
    illegal_i = 1'b0;
    step();
    checks++;
`ifdef SEQ_INSTRET_EN
    if (instret_o !== 64'd10) begin errors++; $display("FAIL instret: got %0d expected 10", instret_o); end
`else
    if (instret_o !== 64'd0) begin errors++; $display("FAIL instret: got %0d expected 0", instret_o); end
`endif
    checks++;
    if (pc_o !== TV) begin errors++; $display("FAIL instret_pc: got %h expected 80000100", pc_o); end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_load_store();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_instret();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the RV32 core. It replaces the fixed free-running FETCH/DECODE/EXEC/WRITE_BACK loop.
- Owns the PC and the instruction register. Drives handshaked instruction and data memory requests, gates register-file writes, computes the next PC and handles traps.
- Sits between the Bram instances, Decoder and reg_file. The datapath (ALU, operand muxing) stays outside.

Parameters:
- XLEN, 32, PC/address width.
- RESET_VEC, 32'h8000_0000, PC value after reset.
- TRAP_VEC, 32'h8000_0100, PC loaded on any trap.
- TIMEOUT, 16, maximum cycles waiting for a memory rvalid before a timeout trap; must be ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- imem_req_o  out  1  instruction fetch request.
- imem_addr_o  out  XLEN  fetch address (= pc_o).
- imem_rvalid_i  in  1  fetch data valid.
- imem_rdata_i  in  32  fetch data.
- inst_o  out  32  registered instruction, fed to the Decoder.
- is_load_i, is_store_i, is_branch_i, is_jal_i, is_jalr_i, illegal_i  in  1 each  decoder flags, valid from DECODE onward.
- branch_taken_i  in  1  branch comparison result, valid in EXEC.
- target_i  in  XLEN  branch/jump target, valid in EXEC.
- rd_i  in  5  destination register.
- dmem_req_o  out  1  data request.
- dmem_we_o  out  1  1 = store (WRITE), 0 = load (READ).
- dmem_rvalid_i  in  1  data access complete.
- rf_we_o  out  1  register-file write strobe.
- pc_o  out  XLEN  current PC.
- retire_o  out  1  one-cycle pulse per retired instruction.
- trap_o  out  1  one-cycle pulse on trap entry.
- trap_cause_o  out  2  0 illegal, 1 fetch timeout, 2 data timeout, 3 misaligned target.
- epc_o  out  XLEN  PC of the faulting instruction.
- instret_o  out  64  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (async, rst_ni=0):
  - state=FETCH, pc=RESET_VEC, inst_o=0, epc_o=0, trap_cause_o=0, timeout count=0.
  - All strobes are 0 while reset is asserted.
  - Reset mid-transaction abandons it; no write strobes follow.
- States: FETCH, DECODE, EXEC, MEM, WRITE_BACK, TRAP. Moore outputs decoded from the state register.
- FETCH:
  - imem_req_o=1 and held until imem_rvalid_i=1.
  - On rvalid, inst_o<=imem_rdata_i and go to DECODE.
  - Minimum 2 cycles in FETCH with a synchronous Bram.
- DECODE: 1 cycle. illegal_i=1 → TRAP with cause 0. Otherwise → EXEC.
- EXEC: 1 cycle. Latches the next PC:
  - jal/jalr, or branch && branch_taken_i → target_i.
  - Otherwise → pc+4, truncated to XLEN (wraps at 2^XLEN).
  - If the chosen target has [1:0]≠0 → TRAP, cause 3.
  - Else load/store → MEM; otherwise → WRITE_BACK.
- MEM:
  - dmem_req_o=1, dmem_we_o=is_store_i, held until dmem_rvalid_i=1, then → WRITE_BACK.
- WRITE_BACK: 1 cycle.
  - rf_we_o=1 iff rd_i≠0 and not (store or branch).
  - pc<=latched next PC, retire_o=1, → FETCH.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments every waiting cycle.
  - Reaching TIMEOUT without rvalid → TRAP, cause 1 (FETCH) or 2 (MEM).
  - rvalid in the same cycle the count reaches TIMEOUT wins: no trap.
- TRAP: 1 cycle.
  - trap_o=1, epc_o<=pc, pc<=TRAP_VEC, → FETCH.
  - No retire, no rf_we_o. trap_cause_o holds until the next trap.
- rvalid inputs outside their wait state are ignored.

Optional Feature:
- Macro: SEQ_INSTRET_EN.
- Defined: 64-bit instret counter, reset 0, +1 on each retire_o, wraps at 2^64. Trapped instructions are not counted.
- Undefined: no counter logic; instret_o is tied to 0.

Decomposition:
- Shared package core_pkg holds:
  - enum seq_state_e (the states listed under Behaviour).
  - enum trap_cause_e.
  - localparams READ=1'b0, WRITE=1'b1.
  - Default reset and trap vectors.
- One sub-module, seq_timeout_counter: clear/enable/expired, parameter TIMEOUT.

Test Plan:
- Reset release with 1-cycle-latency imem returning 32'h0000_0013 (nop) → retire_o every 5 cycles (FETCH ×2, DECODE, EXEC, WRITE_BACK); pc 8000_0000 → 8000_0004 → 8000_0008; rf_we_o=0 since rd=0.
- Load with rd=5, dmem_rvalid after 3 cycles → dmem_req_o high for exactly 3 cycles with dmem_we_o=0, then rf_we_o=1 for 1 cycle; store → rf_we_o stays 0.
- Taken branch target 8000_0040 → next fetch address 8000_0040; target 8000_0042 → trap_o, cause 3, epc=branch PC, pc=8000_0100.
- imem_rvalid_i held 0 with TIMEOUT=16 → trap_o after 16 waiting cycles, cause 1; refetch from 8000_0100. rvalid arriving exactly at count 16 → no trap.
- illegal_i=1 in DECODE → trap cause 0, no retire; rst_ni dropped during MEM → immediate FETCH at RESET_VEC, no rf_we_o.
- With SEQ_INSTRET_EN: 10 nops plus 1 trap → instret_o=10. Without it, instret_o=0 throughout.
